// File: rtl/fp16_pkg.sv
// ============================================================================
//  Module      : fp16_pkg
//  Description : Shared fp16 constants, classification helpers and the
//                accumulator state encoding used across the fp16 calc path.
//  Contents    : FP16_QNAN, FP16_PINF, FP16_PZERO, is_nan(), is_inf(),
//                state_t {S_ACC, S_OUT}
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp16_pkg;

    localparam logic [15:0] FP16_QNAN  = 16'h7E00;
    localparam logic [15:0] FP16_PINF  = 16'h7C00;
    localparam logic [15:0] FP16_PZERO = 16'h0000;

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp16_addsub_unit.sv
// ============================================================================
//  Module      : fp16_addsub_unit
//  Description : Combinational IEEE-754 binary16 adder/subtractor with
//                round-to-nearest-even and subnormal support.
//                Any NaN input or inf-inf yields FP16_QNAN; an exactly zero
//                finite result is always returned as +0.
//  Ports       : a    in  16  first operand
//                b    in  16  second operand
//                sub  in  1   1 = a - b, 0 = a + b
//                y    out 16  rounded result
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp16_addsub_unit
    import fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] y
);

    logic [15:0] w_b_eff;
    logic        w_a_ge_b;
    logic [15:0] w_big;
    logic [15:0] w_sml;
    logic [5:0]  w_e_big;
    logic [5:0]  w_e_sml;
    logic [10:0] w_m_big;
    logic [10:0] w_m_sml;
    logic [5:0]  w_d;
    logic [26:0] w_wide;
    logic [13:0] w_al_big;
    logic [13:0] w_al_sml;
    logic        w_eff_sub;
    logic [14:0] w_v;
    logic [3:0]  w_lz;
    logic [5:0]  w_e_big_m1;
    logic [3:0]  w_shl;
    logic [13:0] w_n;
    logic [5:0]  w_e_n;
    logic [5:0]  w_e_n_m1;
    logic        w_rnd;
    logic [11:0] w_mant_r;
    logic [16:0] w_packed;
    logic [14:0] w_mag;

    assign w_b_eff  = {b[15] ^ sub, b[14:0]};

    // Order operands by magnitude so the aligned difference is never negative.
    assign w_a_ge_b = (a[14:0] >= w_b_eff[14:0]);
    assign w_big    = w_a_ge_b ? a : w_b_eff;
    assign w_sml    = w_a_ge_b ? w_b_eff : a;

    // Subnormals share exponent 1 with the smallest normal, hidden bit 0.
    assign w_e_big  = (w_big[14:10] == 5'h00) ? 6'd1 : {1'b0, w_big[14:10]};
    assign w_e_sml  = (w_sml[14:10] == 5'h00) ? 6'd1 : {1'b0, w_sml[14:10]};
    assign w_m_big  = {(w_big[14:10] != 5'h00), w_big[9:0]};
    assign w_m_sml  = {(w_sml[14:10] != 5'h00), w_sml[9:0]};

    // Three extra bits (guard, round, sticky) below the 11-bit significand;
    // everything shifted past them is OR-folded into the sticky bit.
    assign w_d      = w_e_big - w_e_sml;
    assign w_wide   = {w_m_sml, 16'h0000} >> w_d;
    assign w_al_sml = {w_wide[26:14], w_wide[13] | (|w_wide[12:0])};
    assign w_al_big = {w_m_big, 3'b000};

    assign w_eff_sub = w_big[15] ^ w_sml[15];
    assign w_v = w_eff_sub ? ({1'b0, w_al_big} - {1'b0, w_al_sml})
                           : ({1'b0, w_al_big} + {1'b0, w_al_sml});

    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (w_v[i]) begin
                w_lz = 4'(13 - i);
            end
        end
    end

    // Left normalisation stops at exponent 1 so tiny results stay subnormal.
    assign w_e_big_m1 = w_e_big - 6'd1;
    assign w_shl = (w_e_big_m1 < {2'b00, w_lz}) ? w_e_big_m1[3:0] : w_lz;

    always_comb begin
        w_n   = 14'h0000;
        w_e_n = 6'd1;
        if (w_v[14]) begin
            w_n   = {w_v[14:2], w_v[1] | w_v[0]};
            w_e_n = w_e_big + 6'd1;
        end else begin
            w_n   = w_v[13:0] << w_shl;
            w_e_n = w_e_big - {2'b00, w_shl};
        end
    end

    assign w_rnd    = w_n[2] & (w_n[3] | w_n[1] | w_n[0]);
    assign w_mant_r = {1'b0, w_n[13:3]} + {11'h000, w_rnd};

    // Packing (e-1)<<10 plus the significand with its hidden bit lets a
    // rounding carry bump the exponent and lets a subnormal round up into
    // the normal range without special cases.
    assign w_e_n_m1 = w_e_n - 6'd1;
    assign w_packed = {1'b0, w_e_n_m1, 10'h000} + {5'h00, w_mant_r};
    assign w_mag    = (w_packed >= 17'h07C00) ? FP16_PINF[14:0] : w_packed[14:0];

    always_comb begin
        y = {w_big[15], w_mag};
        if (is_nan(a) || is_nan(b)) begin
            y = FP16_QNAN;
        end else if (is_inf(a) && is_inf(w_b_eff) && (a[15] != w_b_eff[15])) begin
            y = FP16_QNAN;
        end else if (is_inf(a)) begin
            y = a;
        end else if (is_inf(w_b_eff)) begin
            y = w_b_eff;
        end else if (w_v == 15'h0000) begin
            y = FP16_PZERO;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp16_accum_seq.sv
// ============================================================================
//  Module      : fp16_accum_seq
//  Description : Streams fp16 terms over valid/ready, folds one per clock into
//                a running sum and presents sum, term count and sticky
//                NaN/overflow flags on a valid/ready output at end of burst.
//  Ports       : clk, rst (sync active-high), clr (sync abort)
//                in_valid/in_ready/in_data/in_sub/in_last  term stream
//                out_valid/out_ready/out_sum/out_count/out_nan/out_ovf result
//  Parameters  : CNT_W      term counter width
//                MAX_TERMS  burst length that forces end of burst
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp16_accum_seq
    import fp16_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_TERMS = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_ovf
);

    state_t             r_state;
    logic [15:0]        r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_nan;
    logic               r_ovf;
    logic [15:0]        r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_nan;
    logic               r_out_ovf;

    logic               w_accept;
    logic [15:0]        w_sum_nx;
    logic [CNT_W-1:0]   w_count_nx;
    logic               w_nan_nx;
    logic               w_ovf_nx;
    logic               w_end;

    fp16_addsub_unit u_addsub (
        .a   (r_acc),
        .b   (in_data),
        .sub (in_sub),
        .y   (w_sum_nx)
    );

    assign in_ready   = (r_state == S_ACC);
    assign out_valid  = (r_state == S_OUT);
    assign out_sum    = r_out_sum;
    assign out_count  = r_out_count;
    assign out_nan    = r_out_nan;
    assign out_ovf    = r_out_ovf;

    assign w_accept   = in_valid && (r_state == S_ACC);
    assign w_count_nx = r_count + CNT_W'(1);
    assign w_nan_nx   = r_nan | is_nan(w_sum_nx);
    // Overflow means rounding produced infinity from two finite operands;
    // an infinity that was already present is not counted.
    assign w_ovf_nx   = r_ovf | ((w_sum_nx[14:0] == FP16_PINF[14:0]) &&
                                 (r_acc[14:10] != 5'h1F) &&
                                 (in_data[14:10] != 5'h1F));
    // The length cut lands before the counter can wrap.
    assign w_end      = in_last || (w_count_nx == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ACC;
            r_acc       <= FP16_PZERO;
            r_count     <= '0;
            r_nan       <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_sum   <= FP16_PZERO;
            r_out_count <= '0;
            r_out_nan   <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (clr) begin
            r_state     <= S_ACC;
            r_acc       <= FP16_PZERO;
            r_count     <= '0;
            r_nan       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_accept) begin
                        if (w_end) begin
                            r_out_sum   <= w_sum_nx;
                            r_out_count <= w_count_nx;
                            r_out_nan   <= w_nan_nx;
                            r_out_ovf   <= w_ovf_nx;
                            r_acc       <= FP16_PZERO;
                            r_count     <= '0;
                            r_nan       <= 1'b0;
                            r_ovf       <= 1'b0;
                            r_state     <= S_OUT;
                        end else begin
                            r_acc       <= w_sum_nx;
                            r_count     <= w_count_nx;
                            r_nan       <= w_nan_nx;
                            r_ovf       <= w_ovf_nx;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_ACC;
                    end
                end
                default: begin
                    r_state <= S_ACC;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp16_accum_seq.sv
// ============================================================================
//  Module      : tb_fp16_accum_seq
//  Description : Directed self-checking bench for fp16_accum_seq, built with a
//                short burst-length limit so the length cut is reachable.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp16_accum_seq;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_nan;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    fp16_accum_seq #(
        .CNT_W     (CNT_W),
        .MAX_TERMS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_nan   (out_nan),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one term and hold it until the edge that accepts it.
    task automatic send(input string tag, input logic [15:0] d, input logic s, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "/accept_ready"}, {15'h0, in_ready}, 16'h0001);
        tick();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        in_sub   = 1'b1;
        in_last  = 1'b1;
    endtask

    task automatic get_result(input string tag, input logic [15:0] es, input logic [7:0] ec,
                              input logic en, input logic eo);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "/valid"}, {15'h0, out_valid}, 16'h0001);
        chk({tag, "/sum"},   out_sum, es);
        chk({tag, "/count"}, {8'h00, out_count}, {8'h00, ec});
        chk({tag, "/nan"},   {15'h0, out_nan}, {15'h0, en});
        chk({tag, "/ovf"},   {15'h0, out_ovf}, {15'h0, eo});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "/drained"}, {15'h0, out_valid}, 16'h0000);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("reset/in_ready",  {15'h0, in_ready},  16'h0001);
        chk("reset/out_valid", {15'h0, out_valid}, 16'h0000);
        chk("reset/out_sum",   out_sum, 16'h0000);
        chk("reset/out_count", {8'h00, out_count}, 16'h0000);
        chk("reset/flags",     {14'h0, out_nan, out_ovf}, 16'h0000);
        rst = 1'b0;
        tick();

        // 1 + 2 = 3; result visible right after the accepting edge
        send("t1a", 16'h3C00, 1'b0, 1'b0);
        send("t1b", 16'h4000, 1'b0, 1'b1);
        chk("t1/latency", {15'h0, out_valid}, 16'h0001);
        get_result("t1", 16'h4200, 8'd2, 1'b0, 1'b0);

        // exact cancellation gives +0
        send("t2a", 16'h3C00, 1'b0, 1'b0);
        send("t2b", 16'h3C00, 1'b1, 1'b1);
        get_result("t2", 16'h0000, 8'd2, 1'b0, 1'b0);

        // overflow to +inf, flag cleared for the following burst
        send("t3a", 16'h7BFF, 1'b0, 1'b0);
        send("t3b", 16'h7BFF, 1'b0, 1'b1);
        get_result("t3", 16'h7C00, 8'd2, 1'b0, 1'b1);
        send("t3c", 16'h3C00, 1'b0, 1'b1);
        get_result("t3n", 16'h3C00, 8'd1, 1'b0, 1'b0);

        // NaN propagates as canonical quiet NaN and is sticky
        send("t4a", 16'h3C00, 1'b0, 1'b0);
        send("t4b", 16'h7E01, 1'b0, 1'b0);
        send("t4c", 16'h3C00, 1'b0, 1'b1);
        get_result("t4", 16'h7E00, 8'd3, 1'b1, 1'b0);

        // single negated term, then 1 - (1+2^-10) = -2^-10
        send("t7", 16'h3C00, 1'b1, 1'b1);
        get_result("t7", 16'hBC00, 8'd1, 1'b0, 1'b0);
        send("t8a", 16'h3C00, 1'b0, 1'b0);
        send("t8b", 16'h3C01, 1'b1, 1'b1);
        get_result("t8", 16'h9400, 8'd2, 1'b0, 1'b0);

        // ties to even: 2+2^-10 stays 2.0, (2+2^-9)+2^-10 rounds up
        send("t9a", 16'h4000, 1'b0, 1'b0);
        send("t9b", 16'h1400, 1'b0, 1'b1);
        get_result("t9", 16'h4000, 8'd2, 1'b0, 1'b0);
        send("t9c", 16'h4001, 1'b0, 1'b0);
        send("t9d", 16'h1400, 1'b0, 1'b1);
        get_result("t9u", 16'h4002, 8'd2, 1'b0, 1'b0);

        // consumer stall with a term waiting on the input
        send("t5a", 16'h3C00, 1'b0, 1'b0);
        send("t5b", 16'h3C00, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_sub   = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5/hold_valid", {15'h0, out_valid}, 16'h0001);
            chk("t5/hold_ready", {15'h0, in_ready},  16'h0000);
            chk("t5/hold_sum",   out_sum, 16'h4000);
            chk("t5/hold_count", {8'h00, out_count}, 16'h0002);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5/xfer_valid", {15'h0, out_valid}, 16'h0000);
        chk("t5/xfer_ready", {15'h0, in_ready},  16'h0001);
        tick();
        in_valid = 1'b0;
        get_result("t5b", 16'h4000, 8'd1, 1'b0, 1'b0);

        // length cut at 4 terms without in_last
        for (int i = 0; i < 4; i++) begin
            send("t6", 16'h3C00, 1'b0, 1'b0);
        end
        chk("t6/cut_valid", {15'h0, out_valid}, 16'h0001);
        get_result("t6", 16'h4400, 8'd4, 1'b0, 1'b0);

        // reset mid-burst discards the partial sum
        send("t6r", 16'h3C00, 1'b0, 1'b0);
        send("t6r", 16'h3C00, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6r/out_valid", {15'h0, out_valid}, 16'h0000);
        chk("t6r/in_ready",  {15'h0, in_ready},  16'h0001);
        chk("t6r/out_sum",   out_sum, 16'h0000);
        tick();
        send("t6n", 16'h3C00, 1'b0, 1'b1);
        get_result("t6n", 16'h3C00, 8'd1, 1'b0, 1'b0);

        // clr mid-burst, then clr dropping a pending result
        send("tc", 16'h4000, 1'b0, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        send("tc2", 16'h3C00, 1'b0, 1'b1);
        get_result("tc", 16'h3C00, 8'd1, 1'b0, 1'b0);
        send("tco", 16'h3C00, 1'b0, 1'b1);
        chk("tco/pending", {15'h0, out_valid}, 16'h0001);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("tco/dropped", {15'h0, out_valid}, 16'h0000);
        chk("tco/in_ready", {15'h0, in_ready}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
